// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
//   Memory-access pipeline stage sitting after execute. Runs load/store
//   transactions on a req/ack data bus (big-endian byte lanes), stalls the
//   pipeline until each completes, and produces the MEM/WB write-back set
//   plus HI/LO forwarding values.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   aluop_i                  operation code (loads/stores decoded here)
//   mem_addr_i, reg2_i       effective address, store data
//   rw_i, wreg_i, wdata_i    EX write-back set
//   whilo_i, hi_i, lo_i      HI/LO write set (always passed through)
//   dbus_*                   data bus master interface
//   rw_o, wreg_o, wdata_o    write-back set to MEM/WB
//   whilo_o, hi_o, lo_o      HI/LO to MEM/WB and EX forward
//   stall_req                hold all upstream stages
//   align_err, bus_err       one-cycle error pulses
// ---------------------------------------------------------------------------
module mem_access #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  rw_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic        whilo_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic [4:0]  rw_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stall_req,
    output logic        align_err,
    output logic        bus_err
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] load_q, load_d;
    logic        err_q, err_d;

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic        is_load, is_store, is_mem, misalign, mem_ok, timeout;
    logic [3:0]  sel;
    logic [31:0] st_data;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        sel      = 4'b0000;
        st_data  = reg2_i;
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
                sel     = 4'b1000 >> mem_addr_i[1:0];
                st_data = {4{reg2_i[7:0]}};
            end
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
                sel      = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                st_data  = {2{reg2_i[15:0]}};
                misalign = mem_addr_i[0];
            end
            EXE_LW_OP, EXE_SW_OP: begin
                sel      = 4'b1111;
                misalign = (mem_addr_i[1:0] != 2'b00);
            end
            default: ;
        endcase
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load = 1'b1;
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP:                         is_store = 1'b1;
            default: ;
        endcase
    end

    assign is_mem  = is_load | is_store;
    assign mem_ok  = is_mem & ~misalign;
    assign timeout = (state_q == BUSY) && (cnt_q == CNT_LAST);

    // Pick the addressed lane(s) out of a big-endian word and extend.
    function automatic logic [31:0] extract(input logic [7:0]  op,
                                            input logic [1:0]  a,
                                            input logic [31:0] rd);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = $signed(rd[31 - 8*a -: 8]);
        h = $signed(a[1] ? rd[15:0] : rd[31:16]);
        case (op)
            EXE_LB_OP:  extract = 32'(signed'(b));
            EXE_LBU_OP: extract = {24'd0, b};
            EXE_LH_OP:  extract = 32'(signed'(h));
            EXE_LHU_OP: extract = {16'd0, h};
            default:    extract = rd;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            load_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Ack only counts while a request is actually driven,
    // which is why the final BUSY cycle (req dropped) cannot complete.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (mem_ok) begin
                    err_d = 1'b0;
                    cnt_d = 8'd0;
                    if (dbus_ack) begin
                        load_d  = extract(aluop_i, mem_addr_i[1:0], dbus_rdata);
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (dbus_ack) begin
                    load_d  = extract(aluop_i, mem_addr_i[1:0], dbus_rdata);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic. Write-back is suppressed while stalled so a stalled
    // MEM/WB never sees a half-finished load.
    // -----------------------------------------------------------------------
    always_comb begin
        dbus_req   = 1'b0;
        dbus_we    = 1'b0;
        dbus_addr  = 32'd0;
        dbus_sel   = 4'b0000;
        dbus_wdata = 32'd0;
        rw_o       = rw_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        whilo_o    = whilo_i;
        hi_o       = hi_i;
        lo_o       = lo_i;
        stall_req  = 1'b0;
        align_err  = 1'b0;
        bus_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mem && misalign) begin
                    align_err = 1'b1;
                    wreg_o    = 1'b0;
                end else if (mem_ok) begin
                    dbus_req   = 1'b1;
                    dbus_we    = is_store;
                    dbus_addr  = {mem_addr_i[31:2], 2'b00};
                    dbus_sel   = sel;
                    dbus_wdata = st_data;
                    stall_req  = 1'b1;
                    wreg_o     = 1'b0;
                end
            end
            BUSY: begin
                dbus_req   = ~timeout;
                dbus_we    = is_store;
                dbus_addr  = {mem_addr_i[31:2], 2'b00};
                dbus_sel   = sel;
                dbus_wdata = st_data;
                stall_req  = 1'b1;
                wreg_o     = 1'b0;
                bus_err    = timeout;
            end
            DONE: begin
                wreg_o  = wreg_i & ~err_q;
                wdata_o = is_load ? load_q : wdata_i;
            end
            default: ;
        endcase
        if (rst) begin
            dbus_req   = 1'b0;
            dbus_we    = 1'b0;
            dbus_addr  = 32'd0;
            dbus_sel   = 4'b0000;
            dbus_wdata = 32'd0;
            rw_o       = 5'd0;
            wreg_o     = 1'b0;
            wdata_o    = 32'd0;
            whilo_o    = 1'b0;
            hi_o       = 32'd0;
            lo_o       = 32'd0;
            stall_req  = 1'b0;
            align_err  = 1'b0;
            bus_err    = 1'b0;
        end
    end

endmodule
